// File: rtl/me_result_collector.sv
// Motion-estimation result collector: tags each accepted ME result with its block index,
// buffers it in a first-word-fall-through FIFO and reports the per-frame minimum MSAD.
module me_result_collector #(
  parameter  int SAD_W   = 14,
  parameter  int COORD_W = 5,
  parameter  int DEPTH   = 8,
  parameter  int BLOCKS  = 16,
  localparam int IDX_W   = $clog2(BLOCKS),
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               valid_i,
  input  logic [SAD_W-1:0]   sad_i,
  input  logic [COORD_W-1:0] row_i,
  input  logic [COORD_W-1:0] column_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [SAD_W-1:0]   out_sad_o,
  output logic [COORD_W-1:0] out_row_o,
  output logic [COORD_W-1:0] out_column_o,
  output logic [IDX_W-1:0]   out_index_o,
  output logic [LVL_W-1:0]   level_o,
  output logic               overflow_o,
  output logic               frame_done_o,
  output logic [SAD_W-1:0]   best_sad_o,
  output logic [IDX_W-1:0]   best_index_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = SAD_W + 2 * COORD_W + IDX_W;

  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BLOCKS - 1);

  logic [EW-1:0]      fifo_mem [DEPTH];

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  logic [IDX_W-1:0]   blk_idx_q, blk_idx_d;
  logic [SAD_W-1:0]   run_min_q, run_min_d;
  logic [IDX_W-1:0]   run_idx_q, run_idx_d;
  logic               frame_done_q, frame_done_d;
  logic [SAD_W-1:0]   best_sad_q, best_sad_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;

  logic               acc;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               push;
  logic               drop;
  logic               last_blk;
  logic [SAD_W-1:0]   cand_min;
  logic [IDX_W-1:0]   cand_idx;
  logic [EW-1:0]      wr_entry;
  logic [EW-1:0]      head_entry;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign acc        = valid_i & en_i;
  assign fifo_full  = (level_q == LVL_FULL);
  assign fifo_empty = (level_q == '0);
  assign pop        = out_ready_i & ~fifo_empty;
  // A simultaneous pop frees the slot, so a full FIFO can still take the push.
  assign push       = acc & (~fifo_full | pop);
  assign drop       = acc & fifo_full & ~pop;
  assign wr_entry   = {sad_i, row_i, column_i, blk_idx_q};

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | drop;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Block index and frame minimum
  // ---------------------------------------------------------------------------
  assign last_blk = (blk_idx_q == IDX_LAST);

  always_comb begin
    cand_min = run_min_q;
    cand_idx = run_idx_q;
    // Block 0 starts a new frame; afterwards only a strictly smaller SAD wins.
    if (blk_idx_q == '0) begin
      cand_min = sad_i;
      cand_idx = '0;
    end else if (sad_i < run_min_q) begin
      cand_min = sad_i;
      cand_idx = blk_idx_q;
    end
  end

  always_comb begin
    blk_idx_d    = blk_idx_q;
    run_min_d    = run_min_q;
    run_idx_d    = run_idx_q;
    frame_done_d = 1'b0;
    best_sad_d   = best_sad_q;
    best_idx_d   = best_idx_q;
    if (acc) begin
      run_min_d = cand_min;
      run_idx_d = cand_idx;
      if (last_blk) begin
        blk_idx_d    = '0;
        frame_done_d = 1'b1;
        best_sad_d   = cand_min;
        best_idx_d   = cand_idx;
      end else begin
        blk_idx_d = blk_idx_q + IDX_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      blk_idx_q    <= '0;
      run_min_q    <= '0;
      run_idx_q    <= '0;
      frame_done_q <= 1'b0;
      best_sad_q   <= '0;
      best_idx_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      blk_idx_q    <= blk_idx_d;
      run_min_q    <= run_min_d;
      run_idx_q    <= run_idx_d;
      frame_done_q <= frame_done_d;
      best_sad_q   <= best_sad_d;
      best_idx_q   <= best_idx_d;
    end
  end

  // NOTE: the storage array has no reset; validity comes from level_q, and the
  // head outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wr_entry;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign head_entry   = fifo_empty ? '0 : fifo_mem[rd_ptr_q];

  assign out_valid_o  = ~fifo_empty;
  assign out_sad_o    = head_entry[EW-1 -: SAD_W];
  assign out_row_o    = head_entry[IDX_W+COORD_W +: COORD_W];
  assign out_column_o = head_entry[IDX_W +: COORD_W];
  assign out_index_o  = head_entry[IDX_W-1:0];
  assign level_o      = level_q;
  assign overflow_o   = overflow_q;
  assign frame_done_o = frame_done_q;
  assign best_sad_o   = best_sad_q;
  assign best_index_o = best_idx_q;

endmodule

// File: tb/tb_me_result_collector.sv
// Directed bench for me_result_collector: FIFO order/backpressure, overflow,
// frame minimum tracking, enable freeze and mid-frame reset.
module tb_me_result_collector;

  logic        clk;
  logic        rst;
  logic        en_i;
  logic        valid_i;
  logic [13:0] sad_i;
  logic [4:0]  row_i;
  logic [4:0]  column_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [13:0] out_sad_o;
  logic [4:0]  out_row_o;
  logic [4:0]  out_column_o;
  logic [3:0]  out_index_o;
  logic [3:0]  level_o;
  logic        overflow_o;
  logic        frame_done_o;
  logic [13:0] best_sad_o;
  logic [3:0]  best_index_o;

  me_result_collector #(
    .SAD_W(14), .COORD_W(5), .DEPTH(8), .BLOCKS(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en_i),
    .valid_i     (valid_i),
    .sad_i       (sad_i),
    .row_i       (row_i),
    .column_i    (column_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_sad_o   (out_sad_o),
    .out_row_o   (out_row_o),
    .out_column_o(out_column_o),
    .out_index_o (out_index_o),
    .level_o     (level_o),
    .overflow_o  (overflow_o),
    .frame_done_o(frame_done_o),
    .best_sad_o  (best_sad_o),
    .best_index_o(best_index_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] sad;
    logic [4:0]  row;
    logic [4:0]  col;
    logic [3:0]  idx;
  } rec_t;

  rec_t log_q[$];
  int   n_pulse;
  int   n_checks;
  int   n_pass;

  initial n_pulse = 0;

  // Records every entry the consumer takes and every frame_done pulse.
  always @(negedge clk) begin
    if (rst && out_valid_o && out_ready_i)
      log_q.push_back('{out_sad_o, out_row_o, out_column_o, out_index_o});
    if (rst && frame_done_o) n_pulse++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [13:0] s, input logic [4:0] r, input logic [4:0] c);
    valid_i  = 1'b1;
    sad_i    = s;
    row_i    = r;
    column_i = c;
    step();
    valid_i  = 1'b0;
  endtask

  task automatic do_reset();
    valid_i     = 1'b0;
    out_ready_i = 1'b0;
    rst         = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    int   base;
    rec_t r;
    n_checks = 0;
    n_pass   = 0;
    en_i     = 1'b0;
    sad_i    = '0;
    row_i    = '0;
    column_i = '0;
    #2;
    do_reset();

    check("rst_valid",   32'(out_valid_o),  0);
    check("rst_level",   32'(level_o),      0);
    check("rst_sad",     32'(out_sad_o),    0);
    check("rst_ovf",     32'(overflow_o),   0);
    check("rst_done",    32'(frame_done_o), 0);
    check("rst_best",    32'(best_sad_o),   0);
    check("rst_bestidx", 32'(best_index_o), 0);

    // 4 results streamed straight through
    en_i = 1'b1;
    out_ready_i = 1'b1;
    base = log_q.size();
    push(14'd100, 5'd0, 5'd31);
    push(14'd50,  5'd1, 5'd30);
    push(14'd70,  5'd2, 5'd29);
    push(14'd50,  5'd3, 5'd28);
    repeat (4) step();
    check("t1_count", 32'(log_q.size() - base), 4);
    for (int k = 0; k < 4; k++) begin
      r = log_q[base + k];
      check($sformatf("t1_idx%0d", k), 32'(r.idx), 32'(k));
      check($sformatf("t1_row%0d", k), 32'(r.row), 32'(k));
      check($sformatf("t1_col%0d", k), 32'(r.col), 32'(31 - k));
    end
    check("t1_sad0", 32'(log_q[base].sad),     100);
    check("t1_sad1", 32'(log_q[base + 1].sad), 50);
    check("t1_sad2", 32'(log_q[base + 2].sad), 70);
    check("t1_sad3", 32'(log_q[base + 3].sad), 50);
    check("t1_level", 32'(level_o), 0);
    check("t1_ovf",   32'(overflow_o), 0);

    // 9 results into a stalled FIFO: 9th dropped
    do_reset();
    en_i = 1'b1;
    for (int k = 0; k < 9; k++) push(14'(10 + k), 5'(k), 5'(k));
    check("t2_level", 32'(level_o), 8);
    check("t2_ovf",   32'(overflow_o), 1);
    check("t2_head",  32'(out_sad_o), 10);
    base = log_q.size();
    out_ready_i = 1'b1;
    repeat (10) step();
    check("t2_count", 32'(log_q.size() - base), 8);
    for (int k = 0; k < 8; k++) begin
      r = log_q[base + k];
      check($sformatf("t2_idx%0d", k), 32'(r.idx), 32'(k));
      check($sformatf("t2_sad%0d", k), 32'(r.sad), 32'(10 + k));
    end
    check("t2_ovf_sticky", 32'(overflow_o), 1);
    check("t2_level_end",  32'(level_o), 0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    check("t3_ovf_clr", 32'(overflow_o), 0);
    en_i = 1'b1;
    for (int k = 0; k < 8; k++) push(14'(20 + k), 5'(k), 5'(k));
    check("t3_full", 32'(level_o), 8);
    base = log_q.size();
    out_ready_i = 1'b1;
    push(14'd28, 5'd8, 5'd8);
    out_ready_i = 1'b0;
    check("t3_level", 32'(level_o), 8);
    check("t3_ovf",   32'(overflow_o), 0);
    check("t3_head",  32'(out_sad_o), 21);
    step();
    check("t3_stable", 32'(out_sad_o), 21);
    out_ready_i = 1'b1;
    repeat (10) step();
    check("t3_count", 32'(log_q.size() - base), 9);
    for (int k = 0; k < 9; k++) begin
      r = log_q[base + k];
      check($sformatf("t3_sad%0d", k), 32'(r.sad), 32'(20 + k));
      check($sformatf("t3_idx%0d", k), 32'(r.idx), 32'(k));
    end

    // Frame 1: minimum 30 at blocks 5 and 9, earlier wins
    do_reset();
    en_i = 1'b1;
    out_ready_i = 1'b1;
    base = n_pulse;
    for (int k = 0; k < 16; k++) begin
      push((k == 5 || k == 9) ? 14'd30 : 14'(200 + k), 5'(k), 5'(k));
      if (k < 15) check($sformatf("f1_nodone%0d", k), 32'(frame_done_o), 0);
    end
    check("f1_done",    32'(frame_done_o), 1);
    check("f1_best",    32'(best_sad_o),   30);
    check("f1_bestidx", 32'(best_index_o), 5);
    step();
    check("f1_pulse_end", 32'(frame_done_o), 0);
    check("f1_pulses",    32'(n_pulse - base), 1);
    check("f1_held",      32'(best_sad_o), 30);

    // Frame 2: all 500, with an en_i=0 gap that must freeze state
    for (int k = 0; k < 8; k++) push(14'd500, 5'(k), 5'(k));
    check("f2_mid_best", 32'(best_sad_o), 30);
    en_i = 1'b0;
    for (int k = 0; k < 3; k++) push(14'd1, 5'd0, 5'd0);
    check("f2_en_level", 32'(level_o), 0);
    en_i = 1'b1;
    for (int k = 8; k < 16; k++) push(14'd500, 5'(k), 5'(k));
    check("f2_done",    32'(frame_done_o), 1);
    check("f2_best",    32'(best_sad_o),   500);
    check("f2_bestidx", 32'(best_index_o), 0);
    repeat (3) step();
    base = log_q.size();
    push(14'd7, 5'd3, 5'd4);
    repeat (3) step();
    check("f2_wrap_count", 32'(log_q.size() - base), 1);
    check("f2_wrap_idx",   32'(log_q[base].idx), 0);
    check("f2_wrap_sad",   32'(log_q[base].sad), 7);

    // Mid-frame asynchronous reset with 3 entries queued
    do_reset();
    en_i = 1'b1;
    for (int k = 0; k < 3; k++) push(14'(60 + k), 5'(k), 5'(k));
    check("t6_level", 32'(level_o), 3);
    #2;
    rst = 1'b0;
    #1;
    check("t6_valid",   32'(out_valid_o),  0);
    check("t6_level0",  32'(level_o),      0);
    check("t6_sad",     32'(out_sad_o),    0);
    check("t6_index",   32'(out_index_o),  0);
    check("t6_best",    32'(best_sad_o),   0);
    check("t6_bestidx", 32'(best_index_o), 0);
    step();
    rst = 1'b1;
    out_ready_i = 1'b1;
    base = log_q.size();
    push(14'd55, 5'd1, 5'd2);
    repeat (3) step();
    check("t6_count", 32'(log_q.size() - base), 1);
    check("t6_idx",   32'(log_q[base].idx), 0);
    check("t6_sad55", 32'(log_q[base].sad), 55);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
